intr_ctrl_multi: RTL and testbench

//  Parametrised DUART interrupt controller: successor to the fixed 4-source ISR/IMR pair.

---
 rtl/intr_pkg.sv | 30 +++
 rtl/intr_src_cell.sv | 54 +++++
 rtl/intr_ctrl_multi.sv | 127 ++++++++++++
 tb/tb_intr_ctrl_multi.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/intr_pkg.sv
// Shared definitions for the multi-source interrupt controller.
//  - Register map addresses decoded from the 2-bit register select.
//  - MAX_SRC: width of the internal ISR/IMR/IPR vectors (unused bits read 0).
//  - IVR_RESET_DEF: default interrupt vector after reset.
//  - pri_idx(): returns the lowest-numbered set bit (bit 0 = highest priority).
package intr_pkg;

    localparam logic [1:0] A_ISR_IMR = 2'd0;
    localparam logic [1:0] A_IMR     = 2'd1;
    localparam logic [1:0] A_IPR_CLR = 2'd2;
    localparam logic [1:0] A_IVR     = 2'd3;

    localparam int         MAX_SRC       = 8;
    localparam logic [7:0] IVR_RESET_DEF = 8'h0F;

    // Scan from the top down so the lowest set bit is the last one written.
    function automatic logic [2:0] pri_idx(input logic [7:0] vec);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/intr_src_cell.sv
// One interrupt source: synchroniser chain, previous-value flop and
// sticky edge latch with write-1-to-clear.
//  clk_i   system clock
//  rst_ni  asynchronous active-low reset
//  src_i   raw asynchronous source, active high
//  clr_i   write-1-to-clear strobe for this bit (edge mode only)
//  isr_o   ISR bit for this source
module intr_src_cell #(
    parameter logic EDGE        = 1'b0,
    parameter int   SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic src_i,
    input  logic clr_i,
    output logic isr_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   lat_q;
    logic                   s_s;
    logic                   rise_s;

    assign s_s    = sync_q[SYNC_STAGES-1];
    assign rise_s = s_s & ~prev_q;

    // Level bits are taken from prev_q so both modes share the same
    // SYNC_STAGES+1 edge latency from the raw input to the ISR.
    assign isr_o = EDGE ? lat_q : prev_q;

    // Synchroniser, previous-value flop and edge latch (set beats clear).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            lat_q  <= 1'b0;
        end else begin
            sync_q[0] <= src_i;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            prev_q <= s_s;
            if (rise_s) begin
                lat_q <= 1'b1;
            end else if (clr_i) begin
                lat_q <= 1'b0;
            end else begin
                lat_q <= lat_q;
            end
        end
    end

endmodule

// File: rtl/intr_ctrl_multi.sv
// Parametrised DUART interrupt controller.
// Collects NUM_SRC event sources into an ISR, masks them with the IMR and
// drives a registered active-low interrupt request plus read/vector data.
//  clk_i    system clock
//  rst_ni   asynchronous active-low reset
//  cs_i     block select, sampled on clk_i
//  r_w_i    1 = read, 0 = write
//  addr_i   register select (ISR/IMR, IMR, IPR/clear, IVR)
//  data_i   write data
//  iack_ni  interrupt acknowledge, active low
//  src_i    raw asynchronous interrupt sources
//  data_o   registered read / vector data, 0 when idle
//  int_no   registered interrupt request, active low
module intr_ctrl_multi
    import intr_pkg::*;
#(
    parameter int         NUM_SRC     = 8,
    parameter logic [7:0] EDGE_MASK   = 8'hF0,
    parameter int         SYNC_STAGES = 2,
    parameter int         VEC_MODE    = 1,
    parameter logic [7:0] IVR_RESET   = IVR_RESET_DEF
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               cs_i,
    input  logic               r_w_i,
    input  logic [1:0]         addr_i,
    input  logic [7:0]         data_i,
    input  logic               iack_ni,
    input  logic [NUM_SRC-1:0] src_i,
    output logic [7:0]         data_o,
    output logic               int_no
);

    localparam logic [15:0] MASK_W   = (16'd1 << NUM_SRC) - 16'd1;
    localparam logic [7:0]  SRC_MASK = MASK_W[7:0];

    logic [7:0] isr_s;
    logic [7:0] ipr_s;
    logic       wr_s;
    logic       clr_en_s;

    logic [7:0] imr_q, imr_d;
    logic [7:0] ivr_q, ivr_d;
    logic [7:0] data_q, data_d;
    logic       int_q;

    // IACK owns the bus cycle, so writes are suppressed while it is low.
    assign wr_s     = cs_i & ~r_w_i & iack_ni;
    assign clr_en_s = wr_s & (addr_i == A_IPR_CLR);
    assign ipr_s    = isr_s & imr_q;

    for (genvar i = 0; i < MAX_SRC; i++) begin : g_src
        if (i < NUM_SRC) begin : g_on
            intr_src_cell #(
                .EDGE        (EDGE_MASK[i]),
                .SYNC_STAGES (SYNC_STAGES)
            ) u_cell (
                .clk_i  (clk_i),
                .rst_ni (rst_ni),
                .src_i  (src_i[i]),
                .clr_i  (clr_en_s & data_i[i]),
                .isr_o  (isr_s[i])
            );
        end else begin : g_off
            assign isr_s[i] = 1'b0;
        end
    end

    // Register writes: ADDR 0 and 1 both load the IMR, ADDR 3 the IVR.
    always_comb begin
        imr_d = imr_q;
        ivr_d = ivr_q;
        if (wr_s) begin
            case (addr_i)
                A_ISR_IMR, A_IMR: imr_d = data_i & SRC_MASK;
                A_IVR:            ivr_d = data_i;
                default:          imr_d = imr_q;
            endcase
        end else begin
            imr_d = imr_q;
        end
    end

    // Output data: vector on IACK, register on read, zero when deselected.
    always_comb begin
        data_d = data_q;
        if (!iack_ni) begin
            if ((VEC_MODE != 0) && (|ipr_s)) begin
                data_d = {ivr_q[7:3], pri_idx(ipr_s)};
            end else begin
                data_d = ivr_q;
            end
        end else if (cs_i && r_w_i) begin
            case (addr_i)
                A_ISR_IMR: data_d = isr_s;
                A_IMR:     data_d = imr_q;
                A_IPR_CLR: data_d = ipr_s;
                A_IVR:     data_d = ivr_q;
                default:   data_d = 8'h00;
            endcase
        end else if (!cs_i) begin
            data_d = 8'h00;
        end else begin
            data_d = data_q;
        end
    end

    // Control registers and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            imr_q  <= 8'h00;
            ivr_q  <= IVR_RESET;
            data_q <= 8'h00;
            int_q  <= 1'b1;
        end else begin
            imr_q  <= imr_d;
            ivr_q  <= ivr_d;
            data_q <= data_d;
            int_q  <= ~|ipr_s;
        end
    end

    assign data_o = data_q;
    assign int_no = int_q;

endmodule

// File: tb/tb_intr_ctrl_multi.sv
// Scoreboard bench for intr_ctrl_multi with default parameters.
// The driver predicts each edge's outputs from a behavioural model and
// queues them; a negedge monitor pops and compares against the DUT.
module tb_intr_ctrl_multi;

    localparam int         SYNC  = 2;
    localparam logic [7:0] EMASK = 8'hF0;

    logic       clk;
    logic       rst_n;
    logic       cs;
    logic       rw;
    logic [1:0] addr;
    logic [7:0] din;
    logic       iack_n;
    logic [7:0] src;
    logic [7:0] dout;
    logic       int_n;

    typedef struct {
        logic [7:0] d;
        logic       intn;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state
    logic [7:0] m_imr, m_ivr, m_lat, m_dout;
    logic       m_int;
    logic [7:0] hist [0:SYNC];   // hist[0] = most recent sampled SRC

    intr_ctrl_multi dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .cs_i    (cs),
        .r_w_i   (rw),
        .addr_i  (addr),
        .data_i  (din),
        .iack_ni (iack_n),
        .src_i   (src),
        .data_o  (dout),
        .int_no  (int_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_imr  = 8'h00;
        m_ivr  = 8'h0F;
        m_lat  = 8'h00;
        m_dout = 8'h00;
        m_int  = 1'b1;
        for (int j = 0; j <= SYNC; j++) hist[j] = 8'h00;
    endtask

    // Model of one clock edge using the inputs presented to it.
    task automatic model_edge();
        logic [7:0] isr, ipr, rise, clr;
        exp_t e;
        int idx;
        // A raw level becomes ISR-visible SYNC+1 edges after it is sampled.
        isr  = (hist[SYNC] & ~EMASK) | (m_lat & EMASK);
        ipr  = isr & m_imr;
        rise = hist[SYNC-1] & ~hist[SYNC] & EMASK;
        clr  = 8'h00;
        m_int = (ipr == 8'h00);
        if (!iack_n) begin
            idx = -1;
            for (int b = 7; b >= 0; b--) if (ipr[b]) idx = b;
            if (idx >= 0) m_dout = {m_ivr[7:3], 3'(idx)};
            else          m_dout = m_ivr;
        end else if (cs && rw) begin
            case (addr)
                2'd0:    m_dout = isr;
                2'd1:    m_dout = m_imr;
                2'd2:    m_dout = ipr;
                default: m_dout = m_ivr;
            endcase
        end else if (!cs) begin
            m_dout = 8'h00;
        end
        if (cs && !rw && iack_n) begin
            case (addr)
                2'd0, 2'd1: m_imr = din;
                2'd2:       clr   = din;
                default:    m_ivr = din;
            endcase
        end
        m_lat = (m_lat & ~clr) | rise;
        for (int j = SYNC; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = src;
        e.d    = m_dout;
        e.intn = m_int;
        exp_q.push_back(e);
    endtask

    task automatic tick(int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            if (rst_n) model_edge();
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        cs = 1'b1; rw = 1'b0; addr = a; din = d;
        tick();
        cs = 1'b0; rw = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a);
        cs = 1'b1; rw = 1'b1; addr = a;
        tick();
        cs = 1'b0;
    endtask

    task automatic iack();
        iack_n = 1'b0;
        tick();
        iack_n = 1'b1;
    endtask

    task automatic check_reset_outputs();
        n_checks++;
        if (int_n !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_int: got %b expected 1", int_n);
        end
        n_checks++;
        if (dout !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_dout: got %h expected 00", dout);
        end
    endtask

    // Monitor: compares every registered output against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (int_n !== e.intn) begin
                n_fail++;
                $display("FAIL int_n @%0t: got %b expected %b", $time, int_n, e.intn);
            end
            n_checks++;
            if (dout !== e.d) begin
                n_fail++;
                $display("FAIL data_out @%0t: got %h expected %h", $time, dout, e.d);
            end
        end
    end

    initial begin
        rst_n = 1'b0; cs = 1'b0; rw = 1'b1; addr = 2'd0; din = 8'h00;
        iack_n = 1'b1; src = 8'h00;
        model_reset();
        tick(3);
        check_reset_outputs();
        rst_n = 1'b1;
        rd(2'd3);
        rd(2'd1);
        tick();

        // Level source 0
        wr(2'd1, 8'h01);
        src[0] = 1'b1;
        tick(6);
        src[0] = 1'b0;
        tick(6);

        // Edge latch on source 4, then W1C
        wr(2'd1, 8'h10);
        src[4] = 1'b1; tick(3); src[4] = 1'b0;
        tick(5);
        rd(2'd0);
        wr(2'd2, 8'h10);
        tick(2);
        rd(2'd0);

        // Set beats clear on bit 5
        src[5] = 1'b1; tick(4); src[5] = 1'b0; tick(4);
        src[5] = 1'b1; tick(2);
        wr(2'd2, 8'h20);
        rd(2'd0);
        src[5] = 1'b0; tick(3);

        // Masking with ISR = 30
        wr(2'd1, 8'h00);
        src[4] = 1'b1; tick(2); src[4] = 1'b0; tick(4);
        rd(2'd0);
        rd(2'd2);
        wr(2'd1, 8'h20);
        tick();
        rd(2'd0);
        rd(2'd2);

        // IACK vector: IVR=A8, IPR=24, then IPR=00
        wr(2'd3, 8'hA8);
        wr(2'd1, 8'h24);
        src[2] = 1'b1; tick(4);
        rd(2'd2);
        iack();
        tick();
        wr(2'd2, 8'h30);
        src[2] = 1'b0; tick(4);
        iack();
        rd(2'd0);

        // Randomised traffic
        for (int c = 0; c < 400; c++) begin
            cs     = 1'($urandom_range(0, 1));
            rw     = ($urandom_range(0, 3) != 0);
            addr   = 2'($urandom_range(0, 3));
            din    = 8'($urandom);
            iack_n = ($urandom_range(0, 7) != 0);
            for (int b = 0; b < 8; b++) begin
                if ($urandom_range(0, 3) == 0) src[b] = ~src[b];
            end
            tick();
        end
        cs = 1'b0; iack_n = 1'b1;

        // Reset in the middle of activity
        src = 8'hFF; tick(5);
        rst_n = 1'b0;
        #2;
        check_reset_outputs();
        model_reset();
        src = 8'h00;
        tick(2);
        check_reset_outputs();
        rst_n = 1'b1;
        rd(2'd3);
        rd(2'd1);
        rd(2'd0);
        tick(2);

        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
